// File: rtl/match_engine_pkg.sv
// rtl/match_engine_pkg.sv - shared card encodings, FSM state type and helpers for the match engine
package match_engine_pkg;

  localparam int DEF_CARD_ADDRESS_SIZE = 5;
  localparam int DEF_CARD_COLOR_SIZE   = 4;
  localparam int DEF_CARD_STATE_SIZE   = 2;

  localparam int CARD_HIDDEN  = 0;
  localparam int CARD_SHOWN   = 1;
  localparam int CARD_MATCHED = 2;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_FIRST,
    READ_FIRST,
    CHECK_FIRST,
    WAIT_SECOND,
    READ_SECOND,
    CHECK_SECOND,
    MATCH_W1,
    MATCH_W2,
    SHOW_DELAY,
    HIDE_W1,
    HIDE_W2,
    DONE
  } state_t;

  function automatic logic [1:0] next_player(input logic [1:0] cur, input int num_players);
    return (cur == 2'(num_players - 1)) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// rtl/delay_timer.sv - loadable down-counter; done fires on the last cycle of the loaded interval
module delay_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = en && (count == WIDTH'(1));

endmodule

// File: rtl/match_engine.sv
// rtl/match_engine.sv - two-card memory game controller: reveals, matches or hides card pairs and keeps score
module match_engine
  import match_engine_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int CARD_ADDRESS_SIZE = DEF_CARD_ADDRESS_SIZE,
  parameter int CARD_COLOR_SIZE   = DEF_CARD_COLOR_SIZE,
  parameter int CARD_STATE_SIZE   = DEF_CARD_STATE_SIZE,
  parameter int SCORE_SIZE        = 5,
  parameter int HIDE_DELAY        = 65000000
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [CARD_ADDRESS_SIZE:0]                 num_of_cards,
  input  logic                                       card_pressed,
  input  logic [CARD_ADDRESS_SIZE-1:0]               card_clicked_address,
  output logic [CARD_ADDRESS_SIZE-1:0]               rd_address,
  input  logic [CARD_COLOR_SIZE+CARD_STATE_SIZE-1:0] rd_data,
  output logic                                       wr_en,
  output logic [CARD_ADDRESS_SIZE-1:0]               wr_address,
  output logic [CARD_STATE_SIZE-1:0]                 wr_state,
  output logic                                       wait_for_click_en,
  output logic [1:0]                                 current_player,
  output logic [NUM_PLAYERS*SCORE_SIZE-1:0]          scores,
  output logic [CARD_ADDRESS_SIZE-1:0]               pairs_left,
  output logic                                       game_over
);

  localparam int TIMER_W = $clog2(HIDE_DELAY + 1);
  localparam logic [CARD_STATE_SIZE-1:0] ST_HIDDEN  = CARD_STATE_SIZE'(CARD_HIDDEN);
  localparam logic [CARD_STATE_SIZE-1:0] ST_SHOWN   = CARD_STATE_SIZE'(CARD_SHOWN);
  localparam logic [CARD_STATE_SIZE-1:0] ST_MATCHED = CARD_STATE_SIZE'(CARD_MATCHED);

  state_t state_q, state_d;

  logic [CARD_ADDRESS_SIZE-1:0] first_addr;
  logic [CARD_COLOR_SIZE-1:0]   first_color;
  logic [SCORE_SIZE-1:0]        score_q [NUM_PLAYERS];
  logic [CARD_COLOR_SIZE-1:0]   rd_color;
  logic [CARD_STATE_SIZE-1:0]   rd_state;
  logic [CARD_ADDRESS_SIZE-1:0] start_pairs;
  logic                         in_wait;
  logic                         timer_load;
  logic                         timer_done;
  logic                         unused_ok;

  assign {rd_color, rd_state} = rd_data;
  assign start_pairs = num_of_cards[CARD_ADDRESS_SIZE:1];
  assign unused_ok   = num_of_cards[0];
  assign in_wait     = (state_q == WAIT_FIRST) || (state_q == WAIT_SECOND);

  assign wait_for_click_en = in_wait;
  assign game_over         = (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_address = '0;
    wr_state   = '0;
    timer_load = 1'b0;
    case (state_q)
      WAIT_FIRST:  if (card_pressed) state_d = READ_FIRST;
      READ_FIRST:  state_d = CHECK_FIRST;
      CHECK_FIRST: begin
        if (rd_state != ST_HIDDEN) begin
          state_d = WAIT_FIRST;
        end else begin
          wr_en      = 1'b1;
          wr_address = rd_address;
          wr_state   = ST_SHOWN;
          state_d    = WAIT_SECOND;
        end
      end
      WAIT_SECOND: if (card_pressed) state_d = READ_SECOND;
      READ_SECOND: state_d = CHECK_SECOND;
      CHECK_SECOND: begin
        if (rd_address == first_addr || rd_state != ST_HIDDEN) begin
          state_d = WAIT_SECOND;
        end else begin
          wr_en      = 1'b1;
          wr_address = rd_address;
          wr_state   = ST_SHOWN;
          if (rd_color == first_color) begin
            state_d = MATCH_W1;
          end else begin
            timer_load = 1'b1;
            state_d    = SHOW_DELAY;
          end
        end
      end
      // rd_address still holds the second card until the next accepted click
      MATCH_W1: begin
        wr_en      = 1'b1;
        wr_address = first_addr;
        wr_state   = ST_MATCHED;
        state_d    = MATCH_W2;
      end
      MATCH_W2: begin
        wr_en      = 1'b1;
        wr_address = rd_address;
        wr_state   = ST_MATCHED;
        state_d    = (pairs_left <= CARD_ADDRESS_SIZE'(1)) ? DONE : WAIT_FIRST;
      end
      SHOW_DELAY:  if (timer_done) state_d = HIDE_W1;
      HIDE_W1: begin
        wr_en      = 1'b1;
        wr_address = first_addr;
        wr_state   = ST_HIDDEN;
        state_d    = HIDE_W2;
      end
      HIDE_W2: begin
        wr_en      = 1'b1;
        wr_address = rd_address;
        wr_state   = ST_HIDDEN;
        state_d    = WAIT_FIRST;
      end
      default: state_d = state_q;
    endcase
    if (start) begin
      state_d    = (start_pairs == '0) ? DONE : WAIT_FIRST;
      wr_en      = 1'b0;
      wr_address = '0;
      wr_state   = '0;
      timer_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_address     <= '0;
      first_addr     <= '0;
      first_color    <= '0;
      pairs_left     <= '0;
      current_player <= 2'd0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
    end else if (start) begin
      pairs_left     <= start_pairs;
      current_player <= 2'd0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
    end else begin
      if (in_wait && card_pressed) rd_address <= card_clicked_address;
      if (state_q == CHECK_FIRST && rd_state == ST_HIDDEN) begin
        first_addr  <= rd_address;
        first_color <= rd_color;
      end
      if (state_q == MATCH_W2) begin
        if (pairs_left != '0) pairs_left <= pairs_left - CARD_ADDRESS_SIZE'(1);
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (2'(p) == current_player && score_q[p] != '1) score_q[p] <= score_q[p] + SCORE_SIZE'(1);
        end
      end
      if (state_q == HIDE_W2) current_player <= next_player(current_player, NUM_PLAYERS);
    end
  end

  always_comb begin
    scores = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) scores[p*SCORE_SIZE +: SCORE_SIZE] = score_q[p];
  end

  delay_timer #(
    .WIDTH(TIMER_W)
  ) u_delay_timer (
    .clk       (clk),
    .rst_n     (rst),
    .load      (timer_load),
    .load_value(TIMER_W'(HIDE_DELAY)),
    .en        (state_q == SHOW_DELAY),
    .done      (timer_done)
  );

endmodule

// File: tb/tb_match_engine.sv
// tb/tb_match_engine.sv - directed table-driven bench for match_engine with a card-memory model
module tb_match_engine;
  import match_engine_pkg::*;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam int SC = 5;
  localparam int NP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW:0]      num_of_cards;
  logic             card_pressed;
  logic [AW-1:0]    card_clicked_address;
  logic [AW-1:0]    rd_address;
  logic [CW+SW-1:0] rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_address;
  logic [SW-1:0]    wr_state;
  logic             wait_for_click_en;
  logic [1:0]       current_player;
  logic [NP*SC-1:0] scores;
  logic [AW-1:0]    pairs_left;
  logic             game_over;

  match_engine #(
    .NUM_PLAYERS(NP), .CARD_ADDRESS_SIZE(AW), .CARD_COLOR_SIZE(CW),
    .CARD_STATE_SIZE(SW), .SCORE_SIZE(SC), .HIDE_DELAY(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_of_cards(num_of_cards),
    .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
    .rd_address(rd_address), .rd_data(rd_data), .wr_en(wr_en),
    .wr_address(wr_address), .wr_state(wr_state),
    .wait_for_click_en(wait_for_click_en), .current_player(current_player),
    .scores(scores), .pairs_left(pairs_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // card memory: colours set by the stimulus, states owned by the write port
  logic [CW-1:0] colors [32];
  logic [SW-1:0] st [32];
  logic          clr;
  logic [6:0]    wr_hist [128];
  int            wr_count = 0;

  always @(posedge clk) begin
    rd_data <= {colors[rd_address], st[rd_address]};
    if (clr) begin
      for (int i = 0; i < 32; i++) st[i] <= '0;
    end else if (wr_en) begin
      st[wr_address] <= wr_state;
      wr_hist[wr_count[6:0]] <= {wr_address, wr_state};
      wr_count <= wr_count + 1;
    end
  end

  int vec = 0;
  int miss = 0;

  task automatic check(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int w(input int a, input int s);
    return a * 4 + s;
  endfunction

  task automatic press(input int a);
    @(posedge clk); #1;
    card_clicked_address = AW'(a);
    card_pressed = 1'b1;
    @(posedge clk); #1;
    card_pressed = 1'b0;
  endtask

  task automatic click(input int a);
    int n;
    press(a);
    n = 0;
    @(negedge clk);
    while (!(wait_for_click_en || game_over) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("click_timeout", 1, 0);
  endtask

  task automatic do_start(input int n);
    @(posedge clk); #1;
    num_of_cards = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  typedef struct {
    int     addr;
    int     nw;
    int     w0;
    int     w1;
    int     w2;
    state_t st;
    int     player;
    int     pairs;
    int     s0;
    int     s1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int base;
    int cnt;
    int n;

    vecs[0] = '{0, 1, w(0,1), 0, 0, WAIT_SECOND, 0, 2, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, WAIT_SECOND, 0, 2, 0, 0};
    vecs[2] = '{1, 3, w(1,1), w(0,2), w(1,2), WAIT_FIRST, 0, 1, 1, 0};
    vecs[3] = '{0, 0, 0, 0, 0, WAIT_FIRST, 0, 1, 1, 0};
    vecs[4] = '{2, 1, w(2,1), 0, 0, WAIT_SECOND, 0, 1, 1, 0};
    vecs[5] = '{1, 0, 0, 0, 0, WAIT_SECOND, 0, 1, 1, 0};
    vecs[6] = '{3, 3, w(3,1), w(2,2), w(3,2), DONE, 0, 0, 2, 0};

    for (int i = 0; i < 32; i++) colors[i] = CW'(i);
    colors[0] = 4'd3; colors[1] = 4'd3; colors[2] = 4'd5; colors[3] = 4'd5;
    rst = 1'b0; start = 1'b0; card_pressed = 1'b0; clr = 1'b0;
    num_of_cards = '0; card_clicked_address = '0;

    repeat (2) @(negedge clk);
    check("rst_state", int'(dut.state_q), int'(IDLE));
    check("rst_scores", int'(scores), 0);
    check("rst_pairs", int'(pairs_left), 0);
    check("rst_player", int'(current_player), 0);
    check("rst_rd_address", int'(rd_address), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wait_en", int'(wait_for_click_en), 0);
    check("rst_game_over", int'(game_over), 0);
    @(posedge clk); #1 rst = 1'b1;

    clear_mem();
    do_start(4);
    check("start_state", int'(dut.state_q), int'(WAIT_FIRST));
    check("start_pairs", int'(pairs_left), 2);
    check("start_wait_en", int'(wait_for_click_en), 1);

    for (int i = 0; i < 7; i++) begin
      base = wr_count;
      click(vecs[i].addr);
      check($sformatf("v%0d_nwrites", i), wr_count - base, vecs[i].nw);
      if (vecs[i].nw > 0) check($sformatf("v%0d_write0", i), int'(wr_hist[7'(base)]), vecs[i].w0);
      if (vecs[i].nw > 1) check($sformatf("v%0d_write1", i), int'(wr_hist[7'(base + 1)]), vecs[i].w1);
      if (vecs[i].nw > 2) check($sformatf("v%0d_write2", i), int'(wr_hist[7'(base + 2)]), vecs[i].w2);
      check($sformatf("v%0d_state", i), int'(dut.state_q), int'(vecs[i].st));
      check($sformatf("v%0d_player", i), int'(current_player), vecs[i].player);
      check($sformatf("v%0d_pairs", i), int'(pairs_left), vecs[i].pairs);
      check($sformatf("v%0d_score0", i), int'(scores[SC-1:0]), vecs[i].s0);
      check($sformatf("v%0d_score1", i), int'(scores[2*SC-1:SC]), vecs[i].s1);
      check($sformatf("v%0d_game_over", i), int'(game_over), (vecs[i].st == DONE) ? 1 : 0);
    end

    // restart after a finished game; num_of_cards changes later must not matter
    clear_mem();
    colors[0] = 4'd2; colors[2] = 4'd5;
    do_start(4);
    num_of_cards = 6'd8;
    @(negedge clk);
    check("restart_scores", int'(scores), 0);
    check("restart_state", int'(dut.state_q), int'(WAIT_FIRST));
    check("restart_pairs", int'(pairs_left), 2);
    check("restart_game_over", int'(game_over), 0);

    // mismatch: four cycles on display, then both cards hidden and turn passes
    base = wr_count;
    click(0);
    press(2);
    cnt = 0; n = 0;
    @(negedge clk);
    while (!wait_for_click_en && n < 60) begin
      if (dut.state_q == SHOW_DELAY) cnt++;
      @(negedge clk);
      n++;
    end
    check("mm_timeout", n < 60 ? 1 : 0, 1);
    check("mm_delay_cycles", cnt, 4);
    check("mm_nwrites", wr_count - base, 4);
    check("mm_write0", int'(wr_hist[7'(base)]), w(0,1));
    check("mm_write1", int'(wr_hist[7'(base + 1)]), w(2,1));
    check("mm_write2", int'(wr_hist[7'(base + 2)]), w(0,0));
    check("mm_write3", int'(wr_hist[7'(base + 3)]), w(2,0));
    check("mm_player", int'(current_player), 1);
    check("mm_state", int'(dut.state_q), int'(WAIT_FIRST));
    check("mm_pairs", int'(pairs_left), 2);

    // reset in the middle of the display delay
    click(0);
    press(2);
    n = 0;
    while (dut.state_q != SHOW_DELAY && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_reach_delay", int'(dut.state_q), int'(SHOW_DELAY));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rd_state", int'(dut.state_q), int'(IDLE));
    check("rd_wr_en", int'(wr_en), 0);
    check("rd_player", int'(current_player), 0);
    check("rd_pairs", int'(pairs_left), 0);
    check("rd_wait_en", int'(wait_for_click_en), 0);
    base = wr_count;
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    check("rd_no_writes", wr_count - base, 0);
    check("rd_idle_hold", int'(dut.state_q), int'(IDLE));

    // empty deck goes straight to DONE; clicks there are ignored
    do_start(0);
    check("zero_game_over", int'(game_over), 1);
    check("zero_state", int'(dut.state_q), int'(DONE));
    check("zero_pairs", int'(pairs_left), 0);
    base = wr_count;
    press(1);
    repeat (3) @(negedge clk);
    check("done_click_writes", wr_count - base, 0);
    check("done_hold", int'(dut.state_q), int'(DONE));
    do_start(5);
    check("odd_pairs", int'(pairs_left), 2);
    check("odd_state", int'(dut.state_q), int'(WAIT_FIRST));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
